i2c_target_regs: RTL and testbench

- I2C target (slave) responder for the SoC's I2C bus; it is the far end of the I2C controller/CSR block.
- Oversamples SCL/SDA on the system clock, decodes START/STOP/address/data and ACKs its own 7-bit address.
- Exposes a byte register port with an auto-incrementing pointer, so local logic (or a test peripheral) can serve controller writes and reads.
- Used as an on-chip loopback target for controller bring-up and as a general I2C peripheral front end.

---
 rtl/i2c_target_regs.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target responder with a byte register port.
// Oversamples SCL/SDA on clk, decodes START/STOP, ACKs TARGET_ADDR and
// serves controller writes/reads through an auto-incrementing pointer.
// Optional glitch filter: define I2C_TARGET_GLITCH_FILTER_EN to require
// FILTER_LEN consecutive equal samples before a line change is accepted.
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic [3:0] state_debug
);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ACK_ADDR = 4'd2,
    ST_PTR      = 4'd3,
    ST_WDATA    = 4'd4,
    ST_ACK_DATA = 4'd5,
    ST_RDATA    = 4'd6,
    ST_RACK     = 4'd7,
    ST_IGNORE   = 4'd8
  } state_t;

  if (FILTER_LEN < 2 || FILTER_LEN > 7) begin : g_filter_len_check
    $error("FILTER_LEN must be in 2..7");
  end

  logic scl_s1, scl_s2, sda_s1, sda_s2;
  logic scl_f, sda_f;
  logic scl_prev, sda_prev;

  // Two-flop synchronizers; idle bus level is high
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
    end else begin
      scl_s1 <= scl_i;
      scl_s2 <= scl_s1;
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam logic [2:0] CNT_MAX = 3'(FILTER_LEN - 1);
  logic [2:0] scl_cnt, sda_cnt;
  logic       scl_flt, sda_flt;

  // Saturating run counters: a line flips only after FILTER_LEN differing samples
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_flt <= 1'b1;
      sda_flt <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
    end else begin
      if (scl_s2 == scl_flt) begin
        scl_cnt <= '0;
      end else if (scl_cnt == CNT_MAX) begin
        scl_flt <= scl_s2;
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 3'd1;
      end
      if (sda_s2 == sda_flt) begin
        sda_cnt <= '0;
      end else if (sda_cnt == CNT_MAX) begin
        sda_flt <= sda_s2;
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 3'd1;
      end
    end
  end

  assign scl_f = scl_flt;
  assign sda_f = sda_flt;
`else
  assign scl_f = scl_s2;
  assign sda_f = sda_s2;
`endif

  // Previous-sample registers for single-clk edge pulses
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl_f;
      sda_prev <= sda_f;
    end
  end

  logic scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;
  assign scl_rise  =  scl_f & ~scl_prev;
  assign scl_fall  = ~scl_f &  scl_prev;
  assign sda_rise  =  sda_f & ~sda_prev;
  assign sda_fall  = ~sda_f &  sda_prev;
  // SCL must be high both before and after the SDA edge
  assign start_det = sda_fall & scl_f & scl_prev;
  assign stop_det  = sda_rise & scl_f & scl_prev;

  state_t     state, state_nxt;
  logic [3:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic       rw, rw_nxt;
  logic       ack_ok, ack_ok_nxt;
  logic       sda_oe_nxt;
  logic [7:0] reg_addr_nxt, reg_wdata_nxt;
  logic       reg_wr_nxt, reg_rd_nxt, busy_nxt;

  // Next-state and output decode; START/STOP override every state
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shreg_nxt     = shreg;
    rw_nxt        = rw;
    ack_ok_nxt    = ack_ok;
    sda_oe_nxt    = sda_oe;
    reg_addr_nxt  = reg_wr ? reg_addr + 8'd1 : reg_addr;
    reg_wdata_nxt = reg_wdata;
    reg_wr_nxt    = 1'b0;
    reg_rd_nxt    = 1'b0;
    busy_nxt      = busy;

    if (start_det) begin
      state_nxt   = ST_ADDR;
      bit_cnt_nxt = 4'd0;
      sda_oe_nxt  = 1'b0;
      ack_ok_nxt  = 1'b0;
    end else if (stop_det) begin
      state_nxt  = ST_IDLE;
      busy_nxt   = 1'b0;
      sda_oe_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          sda_oe_nxt = 1'b0;
        end
        ST_ADDR: begin
          if (scl_rise) begin
            shreg_nxt = {shreg[6:0], sda_f};
            if (bit_cnt == 4'd7) begin
              // shreg[6:0] holds the address; the bit arriving now is R/W
              if (shreg[6:0] == TARGET_ADDR) begin
                state_nxt = ST_ACK_ADDR;
                busy_nxt  = 1'b1;
                rw_nxt    = sda_f;
              end else begin
                state_nxt = ST_IGNORE;
                busy_nxt  = 1'b0;
              end
            end else begin
              bit_cnt_nxt = bit_cnt + 4'd1;
            end
          end
        end
        ST_ACK_ADDR: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_nxt = 1'b1;
            end else begin
              bit_cnt_nxt = 4'd0;
              if (rw) begin
                state_nxt  = ST_RDATA;
                reg_rd_nxt = 1'b1;
                shreg_nxt  = reg_rdata;
                sda_oe_nxt = ~reg_rdata[7];
              end else begin
                state_nxt  = ST_PTR;
                sda_oe_nxt = 1'b0;
              end
            end
          end
        end
        ST_PTR, ST_WDATA: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shreg_nxt   = {shreg[6:0], sda_f};
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            sda_oe_nxt = 1'b1;
            state_nxt  = ST_ACK_DATA;
            if (state == ST_PTR) begin
              reg_addr_nxt = shreg;
            end else begin
              reg_wdata_nxt = shreg;
              reg_wr_nxt    = 1'b1;
            end
          end
        end
        ST_ACK_DATA: begin
          if (scl_fall) begin
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = 4'd0;
            state_nxt   = ST_WDATA;
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_nxt = 1'b0;
              ack_ok_nxt = 1'b0;
              state_nxt  = ST_RACK;
            end else begin
              shreg_nxt  = {shreg[6:0], 1'b0};
              sda_oe_nxt = ~shreg[6];
            end
          end
        end
        ST_RACK: begin
          if (scl_rise) begin
            if (!sda_f) begin
              ack_ok_nxt   = 1'b1;
              reg_addr_nxt = reg_addr + 8'd1;
            end else begin
              state_nxt  = ST_IGNORE;
              sda_oe_nxt = 1'b0;
            end
          end else if (scl_fall && ack_ok) begin
            reg_rd_nxt  = 1'b1;
            shreg_nxt   = reg_rdata;
            sda_oe_nxt  = ~reg_rdata[7];
            bit_cnt_nxt = 4'd0;
            ack_ok_nxt  = 1'b0;
            state_nxt   = ST_RDATA;
          end
        end
        ST_IGNORE: begin
          sda_oe_nxt = 1'b0;
        end
        default: begin
          state_nxt  = ST_IDLE;
          sda_oe_nxt = 1'b0;
        end
      endcase
    end
  end

  // Control and register-port state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= 4'd0;
      rw        <= 1'b0;
      ack_ok    <= 1'b0;
      sda_oe    <= 1'b0;
      reg_addr  <= 8'd0;
      reg_wdata <= 8'd0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      rw        <= rw_nxt;
      ack_ok    <= ack_ok_nxt;
      sda_oe    <= sda_oe_nxt;
      reg_addr  <= reg_addr_nxt;
      reg_wdata <= reg_wdata_nxt;
      reg_wr    <= reg_wr_nxt;
      reg_rd    <= reg_rd_nxt;
      busy      <= busy_nxt;
    end
  end

  // Shift register is pure data and needs no reset
  always_ff @(posedge clk) begin
    shreg <= shreg_nxt;
  end

  assign state_debug = state;

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: bit-banged I2C controller driving i2c_target_regs,
// with a scoreboard queue of expected register-port strobes.
module tb_i2c_target_regs;

  localparam int Q = 6;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_wr, reg_rd, busy;
  logic [3:0] state_debug;

  assign sda_line  = sda_m & ~sda_oe;
  assign reg_rdata = reg_addr ^ 8'h5A;

  i2c_target_regs #(.TARGET_ADDR(7'h50), .FILTER_LEN(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .scl_i      (scl_m),
    .sda_i      (sda_line),
    .sda_oe     (sda_oe),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .reg_rdata  (reg_rdata),
    .busy       (busy),
    .state_debug(state_debug)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_wr;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  logic oe_seen, busy_seen, saw_addr;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every strobe must match the head of the queue
  always @(negedge clk) begin
    if (reset_n && (reg_wr || reg_rd)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe actual=wr%0b/rd%0b addr=%0h required=none", reg_wr, reg_rd, reg_addr);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("strobe_kind", {7'd0, reg_wr}, {7'd0, e.is_wr});
        check("strobe_addr", reg_addr, e.addr);
        if (e.is_wr) check("strobe_wdata", reg_wdata, e.data);
      end
    end
  end

  always @(negedge clk) begin
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (state_debug == 4'd1) saw_addr = 1'b1;
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wait_q();
    scl_m = 1'b1; wait_q(); wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    b = sda_line; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    write_bit(ack);
  endtask

  function automatic ev_t ev(input logic w, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.is_wr = w; e.addr = a; e.data = d;
    return e;
  endfunction

  initial begin
    logic       ack;
    logic [7:0] d;
    int         n;

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_sda_oe", {7'd0, sda_oe}, 8'd0);
    check("rst_reg_addr", reg_addr, 8'h00);
    check("rst_reg_wdata", reg_wdata, 8'h00);
    check("rst_strobes", {6'd0, reg_wr, reg_rd}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_state", {4'd0, state_debug}, 8'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Write: pointer 0x10, data 0xAB, 0xCD
    exp_q.push_back(ev(1'b1, 8'h10, 8'hAB));
    exp_q.push_back(ev(1'b1, 8'h11, 8'hCD));
    i2c_start();
    write_byte(8'hA0, ack); check("wr_addr_ack", {7'd0, ack}, 8'd0);
    check("wr_busy", {7'd0, busy}, 8'd1);
    write_byte(8'h10, ack); check("wr_ptr_ack", {7'd0, ack}, 8'd0);
    write_byte(8'hAB, ack); check("wr_d0_ack", {7'd0, ack}, 8'd0);
    write_byte(8'hCD, ack); check("wr_d1_ack", {7'd0, ack}, 8'd0);
    i2c_stop();
    repeat (5) @(negedge clk);
    check("wr_final_addr", reg_addr, 8'h12);
    check("wr_busy_after_stop", {7'd0, busy}, 8'd0);
    check("wr_queue_drained", 8'(exp_q.size()), 8'd0);

    // Combined write-pointer / read
    exp_q.push_back(ev(1'b0, 8'h20, 8'h00));
    exp_q.push_back(ev(1'b0, 8'h21, 8'h00));
    i2c_start();
    write_byte(8'hA0, ack); check("rd_waddr_ack", {7'd0, ack}, 8'd0);
    write_byte(8'h20, ack); check("rd_ptr_ack", {7'd0, ack}, 8'd0);
    i2c_rstart();
    write_byte(8'hA1, ack); check("rd_raddr_ack", {7'd0, ack}, 8'd0);
    read_byte(d, 1'b0); check("rd_byte0", d, 8'h7A);
    read_byte(d, 1'b1); check("rd_byte1", d, 8'h7B);
    i2c_stop();
    repeat (5) @(negedge clk);
    check("rd_final_addr", reg_addr, 8'h21);
    check("rd_queue_drained", 8'(exp_q.size()), 8'd0);
    check("rd_state_idle", {4'd0, state_debug}, 8'd0);

    // Address mismatch
    oe_seen = 1'b0; busy_seen = 1'b0;
    i2c_start();
    write_byte(8'hA2, ack); check("mm_addr_nack", {7'd0, ack}, 8'd1);
    write_byte(8'h55, ack); check("mm_data_nack", {7'd0, ack}, 8'd1);
    i2c_stop();
    repeat (5) @(negedge clk);
    check("mm_oe_never", {7'd0, oe_seen}, 8'd0);
    check("mm_busy_never", {7'd0, busy_seen}, 8'd0);
    check("mm_addr_kept", reg_addr, 8'h21);

    // Pointer wrap
    exp_q.push_back(ev(1'b1, 8'hFF, 8'h11));
    exp_q.push_back(ev(1'b1, 8'h00, 8'h22));
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'hFF, ack);
    write_byte(8'h11, ack); check("wrap_d0_ack", {7'd0, ack}, 8'd0);
    write_byte(8'h22, ack); check("wrap_d1_ack", {7'd0, ack}, 8'd0);
    i2c_stop();
    repeat (5) @(negedge clk);
    check("wrap_final_addr", reg_addr, 8'h01);
    check("wrap_queue_drained", 8'(exp_q.size()), 8'd0);

    // Reset while the address ACK is being driven
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(d[0] | 1'b1 ? 1'(8'hA0 >> i) : 1'b0);
    n = 0;
    while (!sda_oe && n < 50) begin @(negedge clk); n++; end
    check("abort_ack_driven", {7'd0, sda_oe}, 8'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_sda_released", {7'd0, sda_oe}, 8'd0);
    check("abort_state_idle", {4'd0, state_debug}, 8'd0);
    sda_m = 1'b1; scl_m = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // START in the middle of a data byte
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h30, ack);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    i2c_rstart();
    check("midstart_state_addr", {4'd0, state_debug}, 8'd1);
    i2c_stop();
    repeat (5) @(negedge clk);
    check("midstart_addr_kept", reg_addr, 8'h30);
    check("midstart_no_write", 8'(exp_q.size()), 8'd0);

    // Short SDA pulses while SCL is high
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    saw_addr = 1'b0;
    sda_m = 1'b0; repeat (2) @(negedge clk); sda_m = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch2_ignored", {7'd0, saw_addr}, 8'd0);
    saw_addr = 1'b0;
    sda_m = 1'b0; repeat (4) @(negedge clk); sda_m = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch4_start", {7'd0, saw_addr}, 8'd1);
`else
    saw_addr = 1'b0;
    sda_m = 1'b0; repeat (2) @(negedge clk); sda_m = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch2_start_unfiltered", {7'd0, saw_addr}, 8'd1);
`endif
    check("glitch_end_idle", {4'd0, state_debug}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
